// File: rtl/addsub_pipe_pkg.sv
// Shared types and helpers for the add/sub pipeline: opcodes, stage record, saturation limits.
package addsub_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDS = 2'd2,
    OP_SUBS = 2'd3
  } op_e;

  localparam int DEF_W = 12;
  localparam int MAX_W = 64;

  // Stage record at the default width; the top declares the same layout at its own W.
  typedef struct packed {
    logic             v;
    logic [DEF_W-1:0] y;
    logic             carry;
    logic             ovf;
  } stage_t;

  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
interface addsub_pipe_if #(parameter int W = 12);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_carry;
  logic         out_ovf;
  logic         busy;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_carry, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_carry, out_ovf, busy
  );
endinterface

// File: rtl/addsub_core.sv
// Combinational add/sub with carry/borrow, signed-overflow flag and optional signed saturation.
module addsub_core
  import addsub_pipe_pkg::*;
#(
  parameter int W = 12
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         carry,
  output logic         ovf
);

  logic         sub, sat;
  logic [W:0]   s;
  logic [W-1:0] b_eff, y_wrap, smax, smin;

  assign sub    = op inside {OP_SUB, OP_SUBS};
  assign sat    = op inside {OP_ADDS, OP_SUBS};
  assign s      = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  assign y_wrap = s[W-1:0];
  assign b_eff  = sub ? (~b + 1'b1) : b;
  assign ovf    = (a[W-1] == b_eff[W-1]) && (y_wrap[W-1] != a[W-1]);
  assign smax   = W'(sat_max(W));
  assign smin   = W'(sat_min(W));

  // s[W] is carry-out for add and borrow (a < b) for sub.
  always_comb begin
    y     = y_wrap;
    carry = s[W];
    if (sat) begin
      carry = 1'b0;
      if (ovf) y = a[W-1] ? smin : smax;
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Handshaked add/sub pipeline of STAGES registers with bubble-collapsing backpressure.
// Optional sticky overflow flag: define ADDSUB_PIPE_OVF_STICKY_EN.
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int W      = 12,
  parameter int STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  addsub_pipe_if.slave bus
`ifdef ADDSUB_PIPE_OVF_STICKY_EN
  ,
  input  logic         ovf_clr,
  output logic         ovf_sticky
`endif
);

  typedef struct packed {
    logic         v;
    logic [W-1:0] y;
    logic         carry;
    logic         ovf;
  } stage_w_t;

  logic [W-1:0]      core_y;
  logic              core_carry, core_ovf;
  stage_w_t          cap;
  logic [STAGES-1:0] vld, adv;

  addsub_core #(.W(W)) u_core (
    .op    (op_e'(bus.in_op)),
    .a     (bus.in_a),
    .b     (bus.in_b),
    .y     (core_y),
    .carry (core_carry),
    .ovf   (core_ovf)
  );

  assign cap = '{v: bus.in_valid, y: core_y, carry: core_carry, ovf: core_ovf};

  // A stage may load whenever it is empty or its contents move on downstream.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !vld[STAGES-1] || bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = !vld[k] || adv[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_w_t r, d;
    if (k == 0) begin : g_in
      assign d = cap;
    end else begin : g_mv
      assign d = g_stage[k-1].r;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst)         r <= '0;
      else if (adv[k]) r <= d;
    assign vld[k] = r.v;
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = g_stage[STAGES-1].r.v;
  assign bus.out_y     = g_stage[STAGES-1].r.y;
  assign bus.out_carry = g_stage[STAGES-1].r.carry;
  assign bus.out_ovf   = g_stage[STAGES-1].r.ovf;
  assign bus.busy      = |vld;

`ifdef ADDSUB_PIPE_OVF_STICKY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)                                               ovf_sticky <= 1'b0;
    else if (bus.out_valid && bus.out_ready && bus.out_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)                                      ovf_sticky <= 1'b0;
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed + random bench for addsub_pipe against an arithmetic reference model and result queue.
module tb_addsub_pipe;
  import addsub_pipe_pkg::*;

  localparam int W      = 12;
  localparam int STAGES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef ADDSUB_PIPE_OVF_STICKY_EN
  logic ovf_clr = 1'b0;
  logic ovf_sticky;
`endif

  addsub_pipe_if #(.W(W)) bus();

  addsub_pipe #(.W(W), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ADDSUB_PIPE_OVF_STICKY_EN
    ,
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  bit   hold_pend = 0;
  exp_t hold_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned operand values.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ai, bi, s, beff;
    bit   sub;
    ai   = int'(a);
    bi   = int'(b);
    sub  = op[0];
    s    = sub ? ai - bi : ai + bi;
    e.y  = W'((s + (1 << W)) % (1 << W));
    e.c  = sub ? (ai < bi) : (s >= (1 << W));
    beff = sub ? ((1 << W) - bi) % (1 << W) : bi;
    e.o  = (a[W-1] == beff[W-1]) && (e.y[W-1] != a[W-1]);
    if (op[1]) begin
      e.c = 1'b0;
      if (e.o) e.y = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return e;
  endfunction

  // One clock: drive, check at negedge against the queue, then step past the edge.
  task automatic cycle(input bit iv, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit ordy, output bit acc);
    exp_t e;
    bus.in_valid  = iv;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = ordy;
    @(negedge clk);
    chk("in_ready", bus.in_ready, !(q.size() == STAGES && !ordy));
    chk("busy", bus.busy, q.size() != 0);
    if (hold_pend) begin
      chk("hold_v", bus.out_valid, 1);
      chk("hold_y", bus.out_y, hold_val.y);
      chk("hold_c", bus.out_carry, hold_val.c);
      chk("hold_o", bus.out_ovf, hold_val.o);
    end
    hold_pend = 0;
    if (bus.out_valid && ordy) begin
      chk("pop_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_y", bus.out_y, e.y);
        chk("out_carry", bus.out_carry, e.c);
        chk("out_ovf", bus.out_ovf, e.o);
      end
    end else if (bus.out_valid) begin
      hold_pend = 1;
      hold_val  = '{bus.out_y, bus.out_carry, bus.out_ovf};
    end
    acc = iv && bus.in_ready;
    if (acc) q.push_back(model(op, a, b));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    bit acc;
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      cycle(0, 2'd0, '0, '0, 1, acc);
      n++;
    end
    chk(tag, q.size(), 0);
  endtask

  // Single transaction into an empty pipe; checks latency and fixed expected results.
  task automatic send_chk(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ey, input logic ec,
                          input logic eo);
    int edges;
    bus.in_valid = 1; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.out_ready = 1;
    @(negedge clk);
    chk({tag, "_acc"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 0;
    edges = 1;
    while (!bus.out_valid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_lat"}, edges, STAGES);
    chk({tag, "_y"}, bus.out_y, ey);
    chk({tag, "_c"}, bus.out_carry, ec);
    chk({tag, "_o"}, bus.out_ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    bit acc;
    int i, cyc;
    bus.in_valid = 0; bus.in_op = 0; bus.in_a = 0; bus.in_b = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_y", bus.out_y, 0);
    chk("rst_carry", bus.out_carry, 0);
    chk("rst_ovf", bus.out_ovf, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
`ifdef ADDSUB_PIPE_OVF_STICKY_EN
    chk("rst_sticky", ovf_sticky, 0);
`endif
    @(posedge clk); #1;

    send_chk("add_ovf", OP_ADD, 12'h7FF, 12'h001, 12'h800, 1'b0, 1'b1);
`ifdef ADDSUB_PIPE_OVF_STICKY_EN
    chk("sticky_set", ovf_sticky, 1);
`endif
    send_chk("adds_sat", OP_ADDS, 12'h7FF, 12'h001, 12'h7FF, 1'b0, 1'b1);
    send_chk("sub_borrow", OP_SUB, 12'h000, 12'h001, 12'hFFF, 1'b1, 1'b0);
    send_chk("subs_sat", OP_SUBS, 12'h800, 12'h001, 12'h800, 1'b0, 1'b1);
    send_chk("add_carry", OP_ADD, 12'hFFF, 12'h002, 12'h001, 1'b1, 1'b0);

    // Backpressure stream: out_ready pattern 1,0,0,1.
    i = 0; cyc = 0;
    while ((i < 10 || q.size() != 0) && cyc < 200) begin
      cycle(i < 10, OP_ADD, W'(i), W'(i), (cyc % 4 == 0) || (cyc % 4 == 3), acc);
      if (acc) i++;
      cyc++;
    end
    chk("bp_all_sent", i, 10);
    chk("bp_drained", q.size(), 0);

    // Bubble collapse: one result parked in the last stage, stage 0 empty.
    cycle(1, OP_ADD, 12'd5, 12'd6, 0, acc);
    cycle(0, OP_ADD, '0, '0, 0, acc);
    chk("bub_parked", bus.out_valid, 1);
    cycle(1, OP_SUB, 12'd7, 12'd8, 0, acc);
    chk("bub_accept", acc, 1);
    cycle(1, OP_ADD, 12'd9, 12'd9, 0, acc);
    chk("bub_refuse", acc, 0);
    drain("bub_drain");

    // Random traffic with random backpressure.
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom % 4) != 0, 2'($urandom), W'($urandom), W'($urandom),
            ($urandom % 3) != 0, acc);
    end
    drain("rand_drain");

`ifdef ADDSUB_PIPE_OVF_STICKY_EN
    cycle(1, OP_ADD, 12'h7FF, 12'h001, 0, acc);
    cycle(0, OP_ADD, '0, '0, 0, acc);
    ovf_clr = 1;
    cycle(0, OP_ADD, '0, '0, 1, acc);
    chk("sticky_set_wins", ovf_sticky, 1);
    cycle(0, OP_ADD, '0, '0, 0, acc);
    chk("sticky_clr", ovf_sticky, 0);
    ovf_clr = 0;
`endif

    // Reset with two results in flight.
    cycle(1, OP_ADD, 12'd1, 12'd1, 0, acc);
    cycle(1, OP_ADD, 12'd2, 12'd2, 0, acc);
    chk("mid_valid_pre", bus.out_valid, 1);
    rst = 1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_y", bus.out_y, 0);
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    hold_pend = 0;
    send_chk("post_rst", OP_SUB, 12'h123, 12'h023, 12'h100, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
